// File: rtl/mcp320x_scan_spi.sv
// mcp320x_scan_spi
//   SPI master for MCP3204/3208-style ADCs (SPI mode 0,0). One frame per
//   conversion: start bit, SGL/DIFF, D2..D0, then the null bit and DATA_W
//   result bits clocked back MSB first. Single-channel or round-robin scan.
//
//   Parameters
//     CLK_DIV  SCLK half-period in clk cycles (1..255)
//     DATA_W   result width (10..16)
//     NUM_CH   number of channels (1..8)
//
//   Ports
//     clk, rst          system clock, async active-high reset
//     start             conversion request (only looked at in IDLE)
//     scan_en           1 = scan all channels, 0 = single channel
//     ch_sel, sgl_diff  single-mode channel and input mode, captured on accept
//     busy              high whenever not IDLE
//     new_data          one-clk pulse, data_out/ch_out valid
//     data_out, ch_out  last result and its channel (held)
//     null_err          sticky: ADC drove 1 during the null bit
//     sclk_pin, cs_n_pin, mosi_pin, miso_pin   SPI pins
module mcp320x_scan_spi #(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              scan_en,
    input  logic [2:0]        ch_sel,
    input  logic              sgl_diff,
    output logic              busy,
    output logic              new_data,
    output logic [DATA_W-1:0] data_out,
    output logic [2:0]        ch_out,
    output logic              null_err,
    output logic              sclk_pin,
    output logic              cs_n_pin,
    output logic              mosi_pin,
    input  logic              miso_pin
);
    localparam int N     = DATA_W + 7;   // SCLK periods per frame
    localparam int DIV_W = 9;

    localparam logic [DIV_W-1:0] HALF_END = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] PER_END  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [4:0]       LAST_BIT = 5'(N);
    localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        bit_cnt;     // current SCLK period, 1-based
    logic [2:0]        cur_ch;
    logic              scan_mode;
    logic              sgl_q;
    logic [DATA_W-1:0] shreg;

    logic       accept;
    logic [2:0] nxt_ch;
    logic       scan_more;

    // Command bit presented on MOSI during SCLK period p.
    function automatic logic cmd_bit(input logic [4:0] p, input logic sgl,
                                     input logic [2:0] ch);
        case (p)
            5'd1:    cmd_bit = 1'b1;
            5'd2:    cmd_bit = sgl;
            5'd3:    cmd_bit = ch[2];
            5'd4:    cmd_bit = ch[1];
            5'd5:    cmd_bit = ch[0];
            default: cmd_bit = 1'b0;
        endcase
    endfunction

    // Out-of-range single-channel requests are dropped silently.
    assign accept    = start && (scan_en || ({1'b0, ch_sel} < 4'(NUM_CH)));
    assign nxt_ch    = (cur_ch == LAST_CH) ? 3'd0 : cur_ch + 3'd1;
    // scan_en is only consulted at the wrap point, so a drop mid-pass
    // still completes the remaining channels.
    assign scan_more = scan_mode && !((cur_ch == LAST_CH) && !scan_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            cur_ch    <= '0;
            scan_mode <= 1'b0;
            sgl_q     <= 1'b0;
            shreg     <= '0;
            busy      <= 1'b0;
            new_data  <= 1'b0;
            data_out  <= '0;
            ch_out    <= '0;
            null_err  <= 1'b0;
            sclk_pin  <= 1'b0;
            cs_n_pin  <= 1'b1;
            mosi_pin  <= 1'b0;
        end else begin
            new_data <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SETUP;
                        busy      <= 1'b1;
                        cs_n_pin  <= 1'b0;
                        mosi_pin  <= 1'b1;
                        div_cnt   <= '0;
                        scan_mode <= scan_en;
                        sgl_q     <= sgl_diff;
                        cur_ch    <= scan_en ? 3'd0 : ch_sel;
                    end
                end
                SETUP: begin
                    if (div_cnt == HALF_END) begin
                        state    <= XFER;
                        div_cnt  <= '0;
                        bit_cnt  <= 5'd1;
                        sclk_pin <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                XFER: begin
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == HALF_END) begin
                        // falling edge: present the bit for the next period
                        sclk_pin <= 1'b0;
                        mosi_pin <= cmd_bit(bit_cnt + 5'd1, sgl_q, cur_ch);
                    end
                    if (div_cnt == PER_END) begin
                        div_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state    <= GAP;
                            cs_n_pin <= 1'b1;
                            data_out <= shreg;
                            ch_out   <= cur_ch;
                            new_data <= 1'b1;
                        end else begin
                            // rising edge of period bit_cnt+1: sample MISO
                            bit_cnt  <= bit_cnt + 5'd1;
                            sclk_pin <= 1'b1;
                            if (bit_cnt == 5'd6)
                                null_err <= null_err | miso_pin;
                            else if (bit_cnt >= 5'd7)
                                shreg <= {shreg[DATA_W-2:0], miso_pin};
                        end
                    end
                end
                GAP: begin
                    if (div_cnt == PER_END) begin
                        div_cnt <= '0;
                        if (scan_more) begin
                            state    <= SETUP;
                            cs_n_pin <= 1'b0;
                            mosi_pin <= 1'b1;
                            cur_ch   <= nxt_ch;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
